// File: rtl/spatz_vrf_port_arbiter_if.sv
// Requester-side and VRF-side signals of one shared VRF port pair.
// slave = arbiter view, master = requesters plus VRF (environment) view.
interface spatz_vrf_port_arbiter_if #(
  parameter int NR_REQ = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  localparam int BE_W = DATA_W / 8;

  logic [NR_REQ-1:0][ADDR_W-1:0] req_waddr;
  logic [NR_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NR_REQ-1:0][BE_W-1:0]   req_wbe;
  logic [NR_REQ-1:0]             req_we;
  logic [NR_REQ-1:0]             req_wvalid;
  logic [NR_REQ-1:0][ADDR_W-1:0] req_raddr;
  logic [NR_REQ-1:0]             req_re;
  logic [DATA_W-1:0]             req_rdata;
  logic [NR_REQ-1:0]             req_rvalid;

  logic [ADDR_W-1:0]             vrf_waddr;
  logic [DATA_W-1:0]             vrf_wdata;
  logic [BE_W-1:0]               vrf_wbe;
  logic                          vrf_we;
  logic                          vrf_wvalid;
  logic [ADDR_W-1:0]             vrf_raddr;
  logic                          vrf_re;
  logic [DATA_W-1:0]             vrf_rdata;
  logic                          vrf_rvalid;

  modport slave (
    input  req_waddr, req_wdata, req_wbe, req_we, req_raddr, req_re,
    input  vrf_wvalid, vrf_rdata, vrf_rvalid,
    output req_wvalid, req_rdata, req_rvalid,
    output vrf_waddr, vrf_wdata, vrf_wbe, vrf_we, vrf_raddr, vrf_re
  );

  modport master (
    output req_waddr, req_wdata, req_wbe, req_we, req_raddr, req_re,
    output vrf_wvalid, vrf_rdata, vrf_rvalid,
    input  req_wvalid, req_rdata, req_rvalid,
    input  vrf_waddr, vrf_wdata, vrf_wbe, vrf_we, vrf_raddr, vrf_re
  );
endinterface

// File: rtl/spatz_vrf_port_arbiter.sv
// Round-robin arbiter with grant lock sharing one VRF write and one read port.
// Optional conflict counters are enabled by defining SPATZ_VRF_ARB_PERF_EN.

// Handshake (both sides): en is the request toward the VRF, ack is the VRF
// accepting it in the same cycle; a grant happens only when en & ack, and an
// ack without en is ignored.
module spatz_vrf_arb_side #(
  parameter  int NR_REQ = 4,
  localparam int IDX_W  = $clog2(NR_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NR_REQ-1:0] req,
  input  logic              ack,
  output logic [IDX_W-1:0]  sel,
  output logic              en,
  output logic [NR_REQ-1:0] valid,
  output logic [IDX_W-1:0]  ptr,
  output logic              locked
);
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, lock_q, lock_d, winner;
  logic             found;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (!found && req[(int'(ptr_q) + i) % NR_REQ]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(ptr_q) + i) % NR_REQ);
      end
    end
  end

  always_comb begin
    sel = '0;
    en  = 1'b0;
    if (state_q == LOCKED) begin
      sel = lock_q;
      en  = req[lock_q];
    end else if (found) begin
      sel = winner;
      en  = 1'b1;
    end
    if (!rst_n) en = 1'b0;
    valid = '0;
    if (en && ack) valid[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (en && !ack) begin
          state_d = LOCKED;
          lock_d  = sel;
        end
      end
      LOCKED: begin
        if (ack || !req[lock_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (en && ack) ptr_d = (sel == IDX_W'(NR_REQ - 1)) ? '0 : sel + 1'b1;
  end

  assign ptr    = ptr_q;
  assign locked = (state_q == LOCKED);
endmodule

module spatz_vrf_port_arbiter #(
  parameter  int NR_REQ    = 4,
  parameter  int CNT_WIDTH = 16,
  parameter  int ADDR_W    = 5,
  parameter  int DATA_W    = 64,
  localparam int IDX_W     = $clog2(NR_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spatz_vrf_port_arbiter_if.slave bus,
  output logic [CNT_WIDTH-1:0] wconf_cnt,
  output logic [CNT_WIDTH-1:0] rconf_cnt,
  output logic                 w_locked,
  output logic                 r_locked,
  output logic [IDX_W-1:0]     w_ptr,
  output logic [IDX_W-1:0]     r_ptr
);
  logic [IDX_W-1:0] w_sel, r_sel;

  spatz_vrf_arb_side #(.NR_REQ(NR_REQ)) i_wside (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus.req_we),
    .ack    (bus.vrf_wvalid),
    .sel    (w_sel),
    .en     (bus.vrf_we),
    .valid  (bus.req_wvalid),
    .ptr    (w_ptr),
    .locked (w_locked)
  );

  spatz_vrf_arb_side #(.NR_REQ(NR_REQ)) i_rside (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (bus.req_re),
    .ack    (bus.vrf_rvalid),
    .sel    (r_sel),
    .en     (bus.vrf_re),
    .valid  (bus.req_rvalid),
    .ptr    (r_ptr),
    .locked (r_locked)
  );

  // With no request, sel stays 0 so requester 0 drives the don't-care data.
  assign bus.vrf_waddr = bus.req_waddr[w_sel];
  assign bus.vrf_wdata = bus.req_wdata[w_sel];
  assign bus.vrf_wbe   = bus.req_wbe[w_sel];
  assign bus.vrf_raddr = bus.req_raddr[r_sel];
  assign bus.req_rdata = bus.vrf_rdata;

`ifdef SPATZ_VRF_ARB_PERF_EN
  logic [CNT_WIDTH-1:0] wcnt_q, rcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      if ($countones(bus.req_we) > 1 && wcnt_q != '1) wcnt_q <= wcnt_q + 1'b1;
      if ($countones(bus.req_re) > 1 && rcnt_q != '1) rcnt_q <= rcnt_q + 1'b1;
    end
  end

  assign wconf_cnt = wcnt_q;
  assign rconf_cnt = rcnt_q;
`else
  assign wconf_cnt = '0;
  assign rconf_cnt = '0;
`endif
endmodule

// File: tb/tb_spatz_vrf_port_arbiter.sv
// Bench for spatz_vrf_port_arbiter: directed vector table, corner sequences,
// and random traffic checked against a queue-fed behavioural model.
module tb_spatz_vrf_port_arbiter;
  localparam int NR   = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SPATZ_VRF_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [NR-1:0] we;
    logic          wack;
    logic [NR-1:0] re;
    logic          rack;
    logic [NR-1:0] exp_wv;
    logic [NR-1:0] exp_rv;
    int            exp_wsel;
    int            exp_rsel;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] wconf_cnt, rconf_cnt;
  logic          w_locked, r_locked;
  logic [1:0]    w_ptr, r_ptr;

  int total = 0;
  int bad   = 0;
  logic [2*NR+1:0] exp_q[$];

  logic [AW-1:0] waddr_tab[NR];
  logic [DW-1:0] wdata_tab[NR];
  logic [BW-1:0] wbe_tab[NR];
  logic [AW-1:0] raddr_tab[NR];

  int m_wptr, m_rptr, m_wlock, m_rlock, m_wcnt, m_rcnt;
  vec_t tbl[12];

  spatz_vrf_port_arbiter_if #(.NR_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  spatz_vrf_port_arbiter #(.NR_REQ(NR), .CNT_WIDTH(CW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .wconf_cnt (wconf_cnt),
    .rconf_cnt (rconf_cnt),
    .w_locked  (w_locked),
    .r_locked  (r_locked),
    .w_ptr     (w_ptr),
    .r_ptr     (r_ptr)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One arbitration side of the model: rotating search from ptr, or the held lock.
  task automatic side_step(input logic [NR-1:0] req, input logic ack, inout int ptr,
                           inout int lock, output int sel, output logic en,
                           output logic [NR-1:0] vld);
    sel = 0;
    en  = 1'b0;
    if (lock >= 0) begin
      sel = lock;
      en  = req[lock];
    end else begin
      for (int off = 0; off < NR; off++) begin
        if (!en && req[(ptr + off) % NR]) begin
          sel = (ptr + off) % NR;
          en  = 1'b1;
        end
      end
    end
    vld = '0;
    if (en && ack) vld[sel] = 1'b1;
    if (lock >= 0) begin
      if (ack || !req[lock]) lock = -1;
    end else if (en && !ack) begin
      lock = sel;
    end
    if (en && ack) ptr = (sel + 1) % NR;
  endtask

  task automatic model_init();
    m_wptr = 0; m_rptr = 0; m_wlock = -1; m_rlock = -1; m_wcnt = 0; m_rcnt = 0;
  endtask

  // Drive one cycle, let it settle and compare against the model; no clock edge.
  task automatic run_cycle(input logic [NR-1:0] we, input logic wack,
                           input logic [NR-1:0] re, input logic rack);
    int wsel, rsel;
    logic wen, ren;
    logic [NR-1:0] wv, rv;
    logic [2*NR+1:0] want;
    bus.req_we     = we;
    bus.vrf_wvalid = wack;
    bus.req_re     = re;
    bus.vrf_rvalid = rack;
    bus.vrf_rdata  = $urandom;
    #2;
    check("wconf_cnt", wconf_cnt, PERF ? m_wcnt : 0);
    check("rconf_cnt", rconf_cnt, PERF ? m_rcnt : 0);
    side_step(we, wack, m_wptr, m_wlock, wsel, wen, wv);
    side_step(re, rack, m_rptr, m_rlock, rsel, ren, rv);
    exp_q.push_back({wv, rv, wen, ren});
    want = exp_q.pop_front();
    check("valid_en", {bus.req_wvalid, bus.req_rvalid, bus.vrf_we, bus.vrf_re}, want);
    check("rdata_bcast", bus.req_rdata, bus.vrf_rdata);
    if (wen) begin
      check("vrf_waddr", bus.vrf_waddr, waddr_tab[wsel]);
      check("vrf_wdata", bus.vrf_wdata, wdata_tab[wsel]);
      check("vrf_wbe", bus.vrf_wbe, wbe_tab[wsel]);
    end
    if (ren) check("vrf_raddr", bus.vrf_raddr, raddr_tab[rsel]);
    if ($countones(we) > 1 && m_wcnt < CMAX) m_wcnt++;
    if ($countones(re) > 1 && m_rcnt < CMAX) m_rcnt++;
  endtask

  // Reset with every request and ack high: nothing may be enabled or granted.
  task automatic do_reset(input logic [NR-1:0] we);
    rst_n          = 1'b0;
    bus.req_we     = we;
    bus.req_re     = '1;
    bus.vrf_wvalid = 1'b1;
    bus.vrf_rvalid = 1'b1;
    #2;
    check("rst_vrf_we", bus.vrf_we, 1'b0);
    check("rst_vrf_re", bus.vrf_re, 1'b0);
    check("rst_wvalid", bus.req_wvalid, '0);
    check("rst_rvalid", bus.req_rvalid, '0);
    tick();
    rst_n          = 1'b1;
    bus.req_we     = '0;
    bus.req_re     = '0;
    bus.vrf_wvalid = 1'b0;
    bus.vrf_rvalid = 1'b0;
    #1;
    check("rst_w_ptr", w_ptr, 0);
    check("rst_r_ptr", r_ptr, 0);
    check("rst_w_locked", w_locked, 1'b0);
    check("rst_r_locked", r_locked, 1'b0);
    check("rst_wconf", wconf_cnt, 0);
    check("rst_rconf", rconf_cnt, 0);
    model_init();
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) begin
      waddr_tab[i] = AW'(i * 7 + 3);
      wdata_tab[i] = $urandom;
      wbe_tab[i]   = BW'($urandom_range(1, (1 << BW) - 1));
      raddr_tab[i] = AW'(i * 5 + 16);
      bus.req_waddr[i] = waddr_tab[i];
      bus.req_wdata[i] = wdata_tab[i];
      bus.req_wbe[i]   = wbe_tab[i];
      bus.req_raddr[i] = raddr_tab[i];
    end
    bus.req_we = '0; bus.req_re = '0; bus.vrf_wvalid = 1'b0; bus.vrf_rvalid = 1'b0;
    bus.vrf_rdata = '0;
    tick();
    do_reset('1);

    // directed vectors, applied back to back from a fresh reset
    tbl[0]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0001, 4'b0000, 0, 0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1, 0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b0100, 4'b0000, 2, 0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0000, 1'b0, 4'b1000, 4'b0000, 3, 0};
    tbl[4]  = '{4'b0110, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 0};
    tbl[5]  = '{4'b0110, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 0};
    tbl[6]  = '{4'b0110, 1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 0};
    tbl[7]  = '{4'b0110, 1'b1, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1, 0};
    tbl[8]  = '{4'b0110, 1'b1, 4'b0000, 1'b0, 4'b0100, 4'b0000, 2, 0};
    tbl[9]  = '{4'b0001, 1'b1, 4'b1000, 1'b1, 4'b0001, 4'b1000, 0, 3};
    tbl[10] = '{4'b0000, 1'b0, 4'b0100, 1'b1, 4'b0000, 4'b0100, 0, 2};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 0};
    for (int i = 0; i < 12; i++) begin
      run_cycle(tbl[i].we, tbl[i].wack, tbl[i].re, tbl[i].rack);
      check($sformatf("tbl%0d_wvalid", i), bus.req_wvalid, tbl[i].exp_wv);
      check($sformatf("tbl%0d_rvalid", i), bus.req_rvalid, tbl[i].exp_rv);
      if (tbl[i].we != '0) check($sformatf("tbl%0d_waddr", i), bus.vrf_waddr, waddr_tab[tbl[i].exp_wsel]);
      if (tbl[i].re != '0) check($sformatf("tbl%0d_raddr", i), bus.vrf_raddr, raddr_tab[tbl[i].exp_rsel]);
      tick();
    end
    // single reader granted back to back
    for (int i = 0; i < 2; i++) begin
      run_cycle(4'b0000, 1'b0, 4'b0100, 1'b1);
      check("b2b_rvalid", bus.req_rvalid, 4'b0100);
      tick();
    end

    // lock on req 2, then it withdraws: no grant, ptr stays at 1
    check("pre_drop_w_ptr", w_ptr, 1);
    run_cycle(4'b0100, 1'b0, 4'b0000, 1'b0);
    tick();
    check("lock_taken", w_locked, 1'b1);
    run_cycle(4'b0000, 1'b1, 4'b0000, 1'b0);
    check("drop_wvalid", bus.req_wvalid, 4'b0000);
    tick();
    check("drop_unlocked", w_locked, 1'b0);
    check("drop_w_ptr", w_ptr, 1);

    // lock holds against a newly eligible requester
    run_cycle(4'b0100, 1'b0, 4'b0000, 1'b0);
    tick();
    run_cycle(4'b0110, 1'b0, 4'b0000, 1'b0);
    check("hold_waddr", bus.vrf_waddr, waddr_tab[2]);
    tick();
    run_cycle(4'b0110, 1'b1, 4'b0000, 1'b0);
    check("hold_grant", bus.req_wvalid, 4'b0100);
    tick();
    check("hold_w_ptr", w_ptr, 3);

    // reset while locked drops the lock without a grant
    run_cycle(4'b0001, 1'b0, 4'b0000, 1'b0);
    tick();
    check("midlock_locked", w_locked, 1'b1);
    do_reset(4'b0001);

    // conflict counters
    for (int i = 0; i < 10; i++) begin
      run_cycle(4'b0000, 1'b0, 4'b0011, 1'b0);
      tick();
    end
    check("rconf_10", rconf_cnt, PERF ? 10 : 0);
    do_reset('1);
    for (int i = 0; i < 20; i++) begin
      run_cycle(4'b1111, 1'b0, 4'b0000, 1'b0);
      tick();
    end
    check("wconf_sat", wconf_cnt, PERF ? CMAX : 0);

    // random traffic against the model
    do_reset('1);
    for (int i = 0; i < 400; i++) begin
      run_cycle(NR'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                NR'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
